// File: rtl/inst_fetch_queue.sv
// Multi-port in-order instruction queue between fetch and decode.
// Accepts up to PUSH_W entries per cycle and presents up to POP_W head entries.
module inst_fetch_queue #(
    parameter int DEPTH  = 16,
    parameter int PUSH_W = 2,
    parameter int POP_W  = 2,
    parameter int DATA_W = 72
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         flush,
    input  logic [PUSH_W-1:0]            in_valid,
    input  logic [PUSH_W*DATA_W-1:0]     in_data,
    output logic                         in_ready,
    output logic [POP_W-1:0]             out_valid,
    output logic [POP_W*DATA_W-1:0]      out_data,
    input  logic [$clog2(POP_W+1)-1:0]   out_pop_cnt,
    output logic [$clog2(DEPTH+1)-1:0]   count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);

    logic [DATA_W-1:0] mem_q [DEPTH];

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic [CNT_W-1:0] push_run;
    logic [CNT_W-1:0] push_cnt;
    logic [CNT_W-1:0] pop_req;
    logic [CNT_W-1:0] pop_cnt;
    logic [CNT_W-1:0] free_cnt;
    logic             run;
    logic [PUSH_W-1:0] wr_en;
    logic [PTR_W-1:0] wr_addr [PUSH_W];
    logic [PTR_W-1:0] rd_addr [POP_W];

    // Readiness depends only on registered occupancy, so ID has no comb path to IF.
    always_comb begin
        free_cnt = CNT_W'(DEPTH) - count_q;
        in_ready = (free_cnt >= CNT_W'(PUSH_W));
    end

    // Only the leading run of valid slots is taken; a hole ends the group.
    always_comb begin
        push_run = '0;
        run      = 1'b1;
        for (int i = 0; i < PUSH_W; i++) begin
            if (run && in_valid[i]) begin
                push_run = push_run + CNT_W'(1);
            end else begin
                run = 1'b0;
            end
        end
        push_cnt = in_ready ? push_run : '0;
    end

    always_comb begin
        pop_req = CNT_W'(out_pop_cnt);
        pop_cnt = (pop_req > count_q) ? count_q : pop_req;
    end

    always_comb begin
        for (int i = 0; i < PUSH_W; i++) begin
            wr_addr[i] = tail_q + PTR_W'(i);
            wr_en[i]   = !reset && !flush && (CNT_W'(i) < push_cnt);
        end
    end

    always_comb begin
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end else begin
            head_d  = head_q + PTR_W'(pop_cnt);
            tail_d  = tail_q + PTR_W'(push_cnt);
            count_d = count_q + push_cnt - pop_cnt;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage carries no reset; validity is tracked solely by count_q.
    always_ff @(posedge clk) begin
        for (int i = 0; i < PUSH_W; i++) begin
            if (wr_en[i]) begin
                mem_q[wr_addr[i]] <= in_data[i*DATA_W +: DATA_W];
            end
        end
    end

    always_comb begin
        out_data = '0;
        for (int i = 0; i < POP_W; i++) begin
            rd_addr[i]   = head_q + PTR_W'(i);
            out_valid[i] = (count_q > CNT_W'(i));
            if (out_valid[i]) begin
                out_data[i*DATA_W +: DATA_W] = mem_q[rd_addr[i]];
            end
        end
    end

    assign count = count_q;

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Bench for inst_fetch_queue: directed scenarios plus randomized traffic,
// all compared against a queue-based reference model every cycle.
module tb_inst_fetch_queue;

    localparam int DEPTH  = 16;
    localparam int PUSH_W = 2;
    localparam int POP_W  = 2;
    localparam int DATA_W = 72;

    logic                       clk;
    logic                       reset;
    logic                       flush;
    logic [PUSH_W-1:0]          in_valid;
    logic [PUSH_W*DATA_W-1:0]   in_data;
    logic                       in_ready;
    logic [POP_W-1:0]           out_valid;
    logic [POP_W*DATA_W-1:0]    out_data;
    logic [1:0]                 out_pop_cnt;
    logic [4:0]                 count;

    int n_chk;
    int n_fail;

    logic [DATA_W-1:0] model_q[$];

    inst_fetch_queue #(
        .DEPTH(DEPTH), .PUSH_W(PUSH_W), .POP_W(POP_W), .DATA_W(DATA_W)
    ) dut (
        .clk(clk),
        .reset(reset),
        .flush(flush),
        .in_valid(in_valid),
        .in_data(in_data),
        .in_ready(in_ready),
        .out_valid(out_valid),
        .out_data(out_data),
        .out_pop_cnt(out_pop_cnt),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [159:0] got, input logic [159:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [DATA_W-1:0] mk(input logic [31:0] pc);
        return {8'h5a, $urandom(), pc};
    endfunction

    // Model state advances with the DUT's clock edge; outputs are compared at the negedge.
    task automatic step(input logic rst, input logic fl, input logic [1:0] iv,
                        input logic [1:0] pop, input logic [DATA_W-1:0] d0,
                        input logic [DATA_W-1:0] d1);
        int n_push;
        int n_pop;
        logic [DATA_W-1:0] exp_slot;
        reset       = rst;
        flush       = fl;
        in_valid    = iv;
        out_pop_cnt = pop;
        in_data     = {d1, d0};
        @(posedge clk);
        if (rst || fl) begin
            model_q.delete();
        end else begin
            n_push = 0;
            if (DEPTH - model_q.size() >= PUSH_W) begin
                if (iv[0]) n_push = iv[1] ? 2 : 1;
            end
            n_pop = (int'(pop) < model_q.size()) ? int'(pop) : model_q.size();
            repeat (n_pop) void'(model_q.pop_front());
            if (n_push >= 1) model_q.push_back(d0);
            if (n_push >= 2) model_q.push_back(d1);
        end
        @(negedge clk);
        chk("count", 160'(count), 160'(model_q.size()));
        chk("in_ready", 160'(in_ready), 160'(DEPTH - model_q.size() >= PUSH_W));
        for (int i = 0; i < POP_W; i++) begin
            exp_slot = (model_q.size() > i) ? model_q[i] : '0;
            chk("out_valid", 160'(out_valid[i]), 160'(model_q.size() > i));
            chk("out_data", 160'(out_data[i*DATA_W +: DATA_W]), 160'(exp_slot));
        end
    endtask

    logic [31:0]       push_pc;
    logic [31:0]       pop_pc;
    logic [DATA_W-1:0] x_ent;
    int                acc;
    int                npop;

    initial begin
        n_chk = 0;
        n_fail = 0;
        reset = 1'b1; flush = 1'b0; in_valid = '0; in_data = '0; out_pop_cnt = '0;

        // Reset held three cycles.
        repeat (3) step(1'b1, 1'b0, 2'b00, 2'd0, '0, '0);
        chk("rst_count", 160'(count), 160'(0));
        chk("rst_ready", 160'(in_ready), 160'(1));
        chk("rst_valid", 160'(out_valid), 160'(0));
        chk("rst_data", 160'(out_data), 160'(0));

        // Fill with pc 0x100.., no pops; ninth push refused when full.
        push_pc = 32'h100;
        for (int k = 0; k < 8; k++) begin
            chk("fill_ready", 160'(in_ready), 160'(1));
            step(1'b0, 1'b0, 2'b11, 2'd0, mk(push_pc), mk(push_pc + 32'd4));
            push_pc += 32'd8;
            chk("fill_count", 160'(count), 160'(2 * (k + 1)));
        end
        chk("full_ready", 160'(in_ready), 160'(0));
        step(1'b0, 1'b0, 2'b11, 2'd0, mk(push_pc), mk(push_pc + 32'd4));
        chk("full_nopush", 160'(count), 160'(16));

        // Drain two per cycle while refilling, across pointer wrap.
        pop_pc = 32'h100;
        for (int k = 0; k < 20; k++) begin
            chk("order0", 160'(out_data[31:0]), 160'(pop_pc));
            chk("order1", 160'(out_data[DATA_W +: 32]), 160'(pop_pc + 32'd4));
            acc  = (DEPTH - model_q.size() >= PUSH_W) ? 2 : 0;
            npop = (model_q.size() < 2) ? model_q.size() : 2;
            step(1'b0, 1'b0, 2'b11, 2'd2, mk(push_pc), mk(push_pc + 32'd4));
            push_pc += 32'(4 * acc);
            pop_pc  += 32'(4 * npop);
        end

        // Conservative ready around count 14/15.
        step(1'b0, 1'b1, 2'b00, 2'd0, '0, '0);
        repeat (7) step(1'b0, 1'b0, 2'b11, 2'd0, mk($urandom()), mk($urandom()));
        chk("c14", 160'(count), 160'(14));
        step(1'b0, 1'b0, 2'b11, 2'd1, mk($urandom()), mk($urandom()));
        chk("c15", 160'(count), 160'(15));
        chk("c15_ready", 160'(in_ready), 160'(0));
        step(1'b0, 1'b0, 2'b00, 2'd2, '0, '0);
        chk("c13", 160'(count), 160'(13));
        chk("c13_ready", 160'(in_ready), 160'(1));

        // Flush beats same-cycle push and pop.
        step(1'b0, 1'b1, 2'b00, 2'd0, '0, '0);
        repeat (3) step(1'b0, 1'b0, 2'b11, 2'd0, mk($urandom()), mk($urandom()));
        chk("c6", 160'(count), 160'(6));
        step(1'b0, 1'b1, 2'b11, 2'd2, mk($urandom()), mk($urandom()));
        chk("flush_count", 160'(count), 160'(0));
        chk("flush_valid", 160'(out_valid), 160'(0));
        x_ent = mk(32'hdead_beef);
        step(1'b0, 1'b0, 2'b01, 2'd0, x_ent, mk($urandom()));
        chk("flush_head", 160'(out_data[DATA_W-1:0]), 160'(x_ent));

        // Partial valid patterns and clamped pop.
        step(1'b0, 1'b0, 2'b01, 2'd0, mk($urandom()), mk($urandom()));
        chk("iv01", 160'(count), 160'(2));
        step(1'b0, 1'b0, 2'b10, 2'd0, mk($urandom()), mk($urandom()));
        chk("iv10", 160'(count), 160'(2));
        step(1'b0, 1'b0, 2'b00, 2'd1, '0, '0);
        step(1'b0, 1'b0, 2'b00, 2'd2, '0, '0);
        chk("clamp", 160'(count), 160'(0));

        // Randomized traffic with occasional flush and reset; phases bias toward full/empty.
        for (int k = 0; k < 3000; k++) begin
            logic [1:0] pop;
            int phase;
            phase = (k / 200) % 3;
            if (phase == 0)      pop = ($urandom_range(0, 3) == 0) ? 2'd1 : 2'd0;
            else if (phase == 1) pop = 2'($urandom_range(1, 2));
            else                 pop = 2'($urandom_range(0, 2));
            step(($urandom_range(0, 299) == 0), ($urandom_range(0, 39) == 0),
                 2'($urandom()), pop, mk($urandom()), mk($urandom()));
        end

        $display("%0d/%0d checks passed", n_chk - n_fail, n_chk);
        $finish;
    end

endmodule
